// File: rtl/product_bcd_converter_pkg.sv
// Shared types and default sizing for the signed-product to BCD converter.
package product_bcd_converter_pkg;

    localparam int DEF_WIDTH  = 10;
    localparam int DEF_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/product_bcd_converter_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // conditional add-3 on one BCD digit
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/product_bcd_converter.sv
// Converts a signed two's-complement product into sign plus packed BCD magnitude,
// one double-dabble step per clock, with valid/ready handshakes on both sides.
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam int                BCD_W     = 4 * DIGITS;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_bin;
    logic [WIDTH-1:0]   w_mag;
    logic [BCD_W-1:0]   r_work;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_work_nxt;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               w_last;
    logic               w_unused_msb;

    // Unsigned WIDTH-bit magnitude: -2^(WIDTH-1) maps onto its own bit pattern, no overflow.
    assign w_mag  = product[WIDTH-1] ? (~product + {{(WIDTH-1){1'b0}}, 1'b1}) : product;
    assign w_last = (r_state == CONV) && (r_cnt == LAST_STEP);

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_work[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // The adjusted top bit is always 0 for an in-range magnitude, so it falls off the shift.
    assign w_work_nxt   = {w_adj[BCD_W-2:0], r_bin[WIDTH-1]};
    assign w_unused_msb = w_adj[BCD_W-1];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign bcd       = r_bcd;
    assign neg       = r_neg;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) w_state_nxt = CONV;
                else          w_state_nxt = IDLE;
            end
            CONV: begin
                if (w_last) w_state_nxt = DONE;
                else        w_state_nxt = CONV;
            end
            DONE: begin
                if (out_ready) w_state_nxt = IDLE;
                else           w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // conversion datapath; bcd output only updates with a finished result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_work <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_neg  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_neg  <= product[WIDTH-1];
                        r_bin  <= w_mag;
                        r_work <= '0;
                        r_cnt  <= '0;
                    end
                end
                CONV: begin
                    r_work <= w_work_nxt;
                    r_bin  <= {r_bin[WIDTH-2:0], 1'b0};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bcd <= w_work_nxt;
                    end
                end
                default: begin
                    r_bcd <= r_bcd;
                end
            endcase
        end
    end

endmodule

// File: doc/product_bcd_converter.md
PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10: bit width of the signed two's-complement product input.
REQ-002 The block SHALL have parameter DIGITS, default 3: number of BCD output digits, sized to hold 2^(WIDTH-1).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  product word available from the upstream Booth multiplier.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a product.
REQ-007 The block SHALL have port product  input  WIDTH  signed two's-complement product.
REQ-008 The block SHALL have port out_valid  output  1  bcd/neg hold a finished result.
REQ-009 The block SHALL have port out_ready  input  1  downstream (display driver) accepts the result.
REQ-010 The block SHALL have port bcd  output  4*DIGITS  magnitude as packed BCD, most significant digit in the top nibble.
REQ-011 The block SHALL have port neg  output  1  sign of the product; 1 = negative.

Function
REQ-012 The block SHALL implement states IDLE, CONV and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, in_valid=1 at a rising edge SHALL:
- capture neg = product[WIDTH-1];
- load the magnitude |product| (WIDTH bits, unsigned) into the binary shift register;
- clear the BCD register and the iteration counter;
- enter CONV.
REQ-015 Each CONV cycle SHALL perform one double-dabble step:
- add 3 to every BCD digit >= 5;
- shift {BCD, binary} left by one bit;
- increment the counter.
REQ-016 CONV SHALL last exactly WIDTH cycles; out_valid SHALL rise WIDTH clock edges after the accepting edge.
REQ-017 In DONE, bcd and neg SHALL hold stable until out_ready=1 at a rising edge; the block SHALL then return to IDLE.
REQ-018 in_valid SHALL be ignored outside IDLE; no input is buffered, and product needs to be valid only on the accepting edge.
REQ-019 A zero product SHALL give bcd=0 and neg=0; negative zero SHALL never be produced.
REQ-020 The most negative input (-2^(WIDTH-1)) SHALL convert correctly. The magnitude is computed WIDTH bits wide as an unsigned value, so no overflow occurs.
REQ-021 bcd SHALL hold the last result (or 0 after reset) outside DONE, and SHALL never show partial conversion values.
REQ-022 Minimum throughput SHALL be one result per WIDTH+2 cycles (accept edge, WIDTH CONV cycles, DONE handshake).

Reset
REQ-023 rst_n=0 SHALL immediately force:
- state = IDLE;
- bcd = 0, neg = 0, out_valid = 0;
- counter = 0, shift registers = 0.
REQ-024 When rst_n deasserts, in_ready SHALL be 1 in the first cycle.
REQ-025 Reset during CONV or DONE SHALL discard the conversion in progress; no out_valid pulse SHALL follow.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE, CONV, DONE) and the default constants WIDTH=10 and DIGITS=3.
REQ-027 The per-digit conditional add-3 SHALL be a combinational sub-module bcd_add3 (4-bit in, 4-bit out), instantiated DIGITS times.
REQ-028 Counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-029 product=10'd117, in_valid one cycle -> after 10 edges out_valid=1, bcd=12'h117, neg=0.
REQ-030 product=10'b1110001011 (-117) -> bcd=12'h117, neg=1.
REQ-031 product=10'b1000000000 (-512) -> bcd=12'h512, neg=1; product=10'd0 -> bcd=12'h000, neg=0.
REQ-032 Result 12'h256 with out_ready=0 held for 5 cycles:
- bcd, neg and out_valid stay stable;
- in_ready stays 0 and in_valid pulses are ignored;
- out_ready=1 -> IDLE the next cycle.
REQ-033 rst_n pulsed low at CONV cycle 4 -> all outputs 0 at once, no out_valid; a new conversion of 10'd37 then gives bcd=12'h037.
REQ-034 Back-to-back products 143, -9, 255 with out_ready=1:
- each result matches its input;
- results come out in input order;
- each result starts WIDTH+2 cycles after the previous one.
